data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 149 ++++++++++++++
 tb/tb_data_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Shared single-port data RAM serving four cores. One access at a time.
//   A load returns data into a per-core result register and pulses rvalid[n].
//   A store writes the RAM at the accepting edge and pulses wdone[n].
//   Requests that are malformed, or that arrive while busy, are dropped.
//   A dropped request pulses err in the following cycle.
//
// Ports
//   clock            single clock, rising edge
//   rst_n            asynchronous active-low reset
//   memory_mode[3:0] 1-4 load core 0-3, 5-8 store core 0-3, others no access
//   mem_rd, mem_wr   read / write strobes, sampled every cycle
//   core_addr0..3    per-core address (ADDR_W)
//   core_wdata0..3   per-core store data (DATA_W)
//   rdata0..3        registered per-core load result
//   rvalid[3:0]      one-cycle load-complete pulse per core
//   wdone[3:0]       one-cycle store-complete pulse per core
//   busy             high whenever the FSM is not IDLE
//   err              one-cycle pulse for a rejected request
module data_mem_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [3:0]        memory_mode,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] core_addr0,
    input  logic [ADDR_W-1:0] core_addr1,
    input  logic [ADDR_W-1:0] core_addr2,
    input  logic [ADDR_W-1:0] core_addr3,
    input  logic [DATA_W-1:0] core_wdata0,
    input  logic [DATA_W-1:0] core_wdata1,
    input  logic [DATA_W-1:0] core_wdata2,
    input  logic [DATA_W-1:0] core_wdata3,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] rdata3,
    output logic [3:0]        rvalid,
    output logic [3:0]        wdone,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, WR_DONE} state_t;

    state_t                  state_q;
    logic [1:0]              core_q;
    logic [ADDR_W-1:0]       addr_q;
    logic                    phase_q;   // RD_WAIT: 0 = address presented, 1 = RAM data ready
    logic [3:0][DATA_W-1:0]  rdata_q;
    logic [3:0]              rvalid_q;
    logic [3:0]              wdone_q;
    logic                    err_q;

    logic [3:0][ADDR_W-1:0]  addr_arr;
    logic [3:0][DATA_W-1:0]  wdata_arr;
    logic [3:0]              rd_n, wr_n;
    logic                    rd_mode, wr_mode;
    logic                    idle, rd_accept, wr_accept, reject;

    logic [DATA_W-1:0]       mem [2**ADDR_W];
    logic [DATA_W-1:0]       ram_q;
    logic [ADDR_W-1:0]       ram_addr;
    logic                    ram_we;

    assign addr_arr  = {core_addr3, core_addr2, core_addr1, core_addr0};
    assign wdata_arr = {core_wdata3, core_wdata2, core_wdata1, core_wdata0};

    assign rd_n    = memory_mode - 4'd1;
    assign wr_n    = memory_mode - 4'd5;
    assign rd_mode = (memory_mode >= 4'd1) && (memory_mode <= 4'd4);
    assign wr_mode = (memory_mode >= 4'd5) && (memory_mode <= 4'd8);

    assign idle      = (state_q == IDLE);
    assign rd_accept = idle && mem_rd && !mem_wr && rd_mode;
    assign wr_accept = idle && mem_wr && !mem_rd && wr_mode;
    // Any strobe that is not accepted is an error: covers both-strobes,
    // wrong mode for the strobe, and any strobe while busy.
    assign reject    = (mem_rd || mem_wr) && !rd_accept && !wr_accept;

    // Writes are gated by rst_n so no write can slip in while reset is held.
    assign ram_we   = wr_accept && rst_n;
    assign ram_addr = ram_we ? addr_arr[wr_n[1:0]] : addr_q;

    // Single-port RAM, registered read, contents not reset.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[ram_addr] <= wdata_arr[wr_n[1:0]];
        end
        ram_q <= mem[ram_addr];
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            core_q   <= '0;
            addr_q   <= '0;
            phase_q  <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= '0;
            wdone_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= '0;
            wdone_q  <= '0;
            err_q    <= reject;
            case (state_q)
                IDLE: begin
                    if (rd_accept) begin
                        core_q  <= rd_n[1:0];
                        addr_q  <= addr_arr[rd_n[1:0]];
                        phase_q <= 1'b0;
                        state_q <= RD_WAIT;
                    end else if (wr_accept) begin
                        wdone_q[wr_n[1:0]] <= 1'b1;
                        state_q            <= WR_DONE;
                    end
                end
                RD_WAIT: begin
                    // First cycle lets the RAM register mem[addr_q] into
                    // ram_q; second cycle hands it to the core.
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        rdata_q[core_q]  <= ram_q;
                        rvalid_q[core_q] <= 1'b1;
                        state_q          <= RD_DONE;
                    end
                end
                RD_DONE: state_q <= IDLE;
                WR_DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata0 = rdata_q[0];
    assign rdata1 = rdata_q[1];
    assign rdata2 = rdata_q[2];
    assign rdata3 = rdata_q[3];
    assign rvalid = rvalid_q;
    assign wdone  = wdone_q;
    assign busy   = !idle;
    assign err    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [3:0]  memory_mode;
    logic        mem_rd, mem_wr;
    logic [7:0]  core_addr0, core_addr1, core_addr2, core_addr3;
    logic [15:0] core_wdata0, core_wdata1, core_wdata2, core_wdata3;
    logic [15:0] rdata0, rdata1, rdata2, rdata3;
    logic [3:0]  rvalid, wdone;
    logic        busy, err;

    int n_chk  = 0;
    int n_pass = 0;

    data_mem_responder #(.DATA_W(16), .ADDR_W(8)) dut (
        .clock(clock), .rst_n(rst_n), .memory_mode(memory_mode),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .core_addr0(core_addr0), .core_addr1(core_addr1),
        .core_addr2(core_addr2), .core_addr3(core_addr3),
        .core_wdata0(core_wdata0), .core_wdata1(core_wdata1),
        .core_wdata2(core_wdata2), .core_wdata3(core_wdata3),
        .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
        .rvalid(rvalid), .wdone(wdone), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] rdat(input int c);
        case (c)
            0: return rdata0;
            1: return rdata1;
            2: return rdata2;
            default: return rdata3;
        endcase
    endfunction

    task automatic set_core(input int c, input logic [7:0] a, input logic [15:0] d);
        case (c)
            0: begin core_addr0 = a; core_wdata0 = d; end
            1: begin core_addr1 = a; core_wdata1 = d; end
            2: begin core_addr2 = a; core_wdata2 = d; end
            default: begin core_addr3 = a; core_wdata3 = d; end
        endcase
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20) begin
            cyc();
            k++;
        end
        chk("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_store(input int c, input logic [7:0] a, input logic [15:0] d);
        wait_idle();
        set_core(c, a, d);
        memory_mode = 4'(5 + c);
        mem_wr = 1'b1;
        cyc();
        mem_wr = 1'b0;
        memory_mode = 4'd0;
        chk("st_wdone", {28'd0, wdone}, 32'(1 << c));
        chk("st_busy", {31'd0, busy}, 32'd1);
        cyc();
        chk("st_wdone_off", {28'd0, wdone}, 32'd0);
        chk("st_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_load(input int c, input logic [7:0] a, input logic [15:0] exp);
        wait_idle();
        set_core(c, a, 16'h0000);
        memory_mode = 4'(1 + c);
        mem_rd = 1'b1;
        cyc();
        mem_rd = 1'b0;
        memory_mode = 4'd0;
        chk("ld_rv_t0", {28'd0, rvalid}, 32'd0);
        cyc();
        chk("ld_rv_t1", {28'd0, rvalid}, 32'd0);
        cyc();
        chk("ld_rvalid", {28'd0, rvalid}, 32'(1 << c));
        chk("ld_rdata", {16'd0, rdat(c)}, {16'd0, exp});
        cyc();
        chk("ld_rv_off", {28'd0, rvalid}, 32'd0);
        chk("ld_hold", {16'd0, rdat(c)}, {16'd0, exp});
    endtask

    // One illegal strobe: err next cycle only, no completion, no busy.
    task automatic bad_req(input string tag, input logic [3:0] m, input logic r, input logic w);
        memory_mode = m;
        mem_rd = r;
        mem_wr = w;
        cyc();
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        memory_mode = 4'd0;
        chk({tag, "_err"}, {31'd0, err}, 32'd1);
        chk({tag, "_flags"}, {23'd0, rvalid, wdone, busy}, 32'd0);
        cyc();
        chk({tag, "_err_off"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        logic [8:0] a9;
        rst_n = 1'b0;
        memory_mode = 4'd0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        core_addr0 = '0; core_addr1 = '0; core_addr2 = '0; core_addr3 = '0;
        core_wdata0 = '0; core_wdata1 = '0; core_wdata2 = '0; core_wdata3 = '0;
        #1;
        chk("rst_rdata", {rdata0 | rdata1 | rdata2 | rdata3}, 32'd0);
        chk("rst_flags", {22'd0, rvalid, wdone, busy, err}, 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_idle", {22'd0, rvalid, wdone, busy, err}, 32'd0);

        // Store then load on core 1; other cores' results stay at zero.
        do_store(1, 8'h10, 16'hBEEF);
        do_load(1, 8'h10, 16'hBEEF);
        chk("other_rdata", {rdata0 | rdata2 | rdata3}, 32'd0);

        // Fill 0x01-0x04, then four back-to-back loads, one per core.
        for (int i = 0; i < 4; i++) do_store(0, 8'(i + 1), 16'(8'hA1 + i));
        for (int i = 0; i < 4; i++) do_load(i, 8'(i + 1), 16'(8'hA1 + i));
        chk("all_rdata", {rdata3[7:0], rdata2[7:0], rdata1[7:0], rdata0[7:0]}, 32'hA4A3A2A1);

        // Illegal requests; core0 data aims at 0x01 to catch a stray write.
        set_core(0, 8'h01, 16'hDEAD);
        bad_req("rd_mode7", 4'd7, 1'b1, 1'b0);
        bad_req("wr_mode0", 4'd0, 1'b0, 1'b1);
        bad_req("both_mode1", 4'd1, 1'b1, 1'b1);
        set_core(1, 8'h01, 16'hDEAD);
        bad_req("wr_mode6_rd", 4'd6, 1'b1, 1'b1);
        // Mode alone, no strobe: nothing happens.
        memory_mode = 4'd6;
        cyc();
        memory_mode = 4'd0;
        chk("no_strobe", {22'd0, rvalid, wdone, busy, err}, 32'd0);
        do_load(2, 8'h01, 16'h00A1);

        // Strobe while busy: err, load still completes.
        wait_idle();
        set_core(2, 8'h10, 16'h0000);
        memory_mode = 4'd3;
        mem_rd = 1'b1;
        cyc();
        mem_rd = 1'b0;
        memory_mode = 4'd5;
        set_core(0, 8'h10, 16'h5555);
        mem_wr = 1'b1;
        cyc();
        mem_wr = 1'b0;
        memory_mode = 4'd0;
        chk("busy_err", {31'd0, err}, 32'd1);
        cyc();
        chk("busy_rvalid", {28'd0, rvalid}, 32'b0100);
        chk("busy_rdata", {16'd0, rdata2}, 32'h0000BEEF);
        chk("busy_err_off", {31'd0, err}, 32'd0);

        // Reset during RD_WAIT.
        wait_idle();
        set_core(3, 8'h10, 16'h0000);
        memory_mode = 4'd4;
        mem_rd = 1'b1;
        cyc();
        mem_rd = 1'b0;
        memory_mode = 4'd0;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdata", {rdata0 | rdata1 | rdata2 | rdata3}, 32'd0);
        chk("mid_rst_flags", {22'd0, rvalid, wdone, busy, err}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        chk("mid_no_rvalid", {22'd0, rvalid, wdone, busy, err}, 32'd0);
        do_load(3, 8'h10, 16'hBEEF);

        // Address truncation: 0x1FF lands on 0xFF.
        a9 = 9'h1FF;
        do_store(0, a9[7:0], 16'h1234);
        do_load(1, 8'hFF, 16'h1234);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
